uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side handshake between uart_rx and the data memory peripheral / CPU.
// The receiver drives the byte and status flags; the reader returns rd_ack.
interface uart_rx_if;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       overrun;
  logic       frame_err;
  logic       irq;

  modport master (
    input  rd_ack,
    output rx_data, rx_valid, rx_ready, overrun, frame_err, irq
  );

  modport slave (
    output rd_ack,
    input  rx_data, rx_valid, rx_ready, overrun, frame_err, irq
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with start-bit glitch rejection, sticky ready/overrun/framing
// flags and a byte-available interrupt.
//
// state | meaning
// IDLE  | waiting for a fresh falling edge on the synchronized line
// START | counting to mid start bit, then confirming it is still low
// DATA  | sampling 8 data bits LSB first at mid-bit
// STOP  | sampling the stop bit and publishing or flagging the byte
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx,
  uart_rx_if.master bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

  logic        rx_meta, rx_s, rx_d;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ready_q, ready_d;
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ready_d = ready_q;
    ovr_d   = ovr_q;
    ferr_d  = ferr_q;

    if (bus.rd_ack) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
      ferr_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Edge-triggered start so a held-low break line never re-arms a frame.
        if (rx_d && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_CNT) begin
          shift_d[idx_q] = rx_s;
          cnt_d = '0;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ready_d = 1'b1;
            if (ready_q && !bus.rd_ack) ovr_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.rx_ready  = ready_q;
  assign bus.overrun   = ovr_q;
  assign bus.frame_err = ferr_q;
  assign bus.irq       = ready_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: framing, overrun, framing
// error with break, glitch rejection, rd_ack/stop collision and mid-frame reset.
module tb_uart_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;

  int total = 0;
  int bad = 0;
  int vcnt = 0;
  int vbase = 0;
  logic prev_v = 1'b0;
  logic dbl = 1'b0;

  uart_rx_if u_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (u_if.rx_valid && prev_v) dbl = 1'b1;
    if (u_if.rx_valid) vcnt++;
    prev_v = u_if.rx_valid;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic check_flags(input string tag, input logic [7:0] data, input logic rdy,
                             input logic ovr, input logic ferr);
    chk({tag, "_data"}, 16'(u_if.rx_data), 16'(data));
    chk({tag, "_ready"}, 16'(u_if.rx_ready), 16'(rdy));
    chk({tag, "_irq"}, 16'(u_if.irq), 16'(rdy));
    chk({tag, "_ovr"}, 16'(u_if.overrun), 16'(ovr));
    chk({tag, "_ferr"}, 16'(u_if.frame_err), 16'(ferr));
  endtask

  // Leaves rx at the stop-bit value; optional rd_ack in the stop-sample cycle,
  // which lands on edge 155 after the start-bit falling edge.
  task automatic send(input logic [7:0] b, input logic stop_bit, input logic ack_at_stop);
    @(posedge clk); #1 rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = stop_bit;
    if (ack_at_stop) begin
      repeat (10) @(posedge clk);
      #1 u_if.rd_ack = 1'b1;
      @(posedge clk);
      #1 u_if.rd_ack = 1'b0;
      repeat (5) @(posedge clk);
    end else begin
      repeat (CPB) @(posedge clk);
    end
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack();
    @(posedge clk); #1 u_if.rd_ack = 1'b1;
    @(posedge clk); #1 u_if.rd_ack = 1'b0;
  endtask

  initial begin
    u_if.rd_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 16'(u_if.rx_valid), 16'd0);
    check_flags("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(10);

    vbase = vcnt;
    send(8'hA5, 1'b1, 1'b0);
    idle(4);
    chk("a5_pulses", 16'(vcnt - vbase), 16'd1);
    check_flags("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    ack();
    chk("a5_ack_ready", 16'(u_if.rx_ready), 16'd0);

    vbase = vcnt;
    send(8'h3C, 1'b1, 1'b0);
    idle(4);
    chk("3c_data", 16'(u_if.rx_data), 16'h3C);
    send(8'hC3, 1'b1, 1'b0);
    idle(4);
    chk("ovr_pulses", 16'(vcnt - vbase), 16'd2);
    check_flags("ovr", 8'hC3, 1'b1, 1'b1, 1'b0);
    ack();
    check_flags("ovr_ack", 8'hC3, 1'b0, 1'b0, 1'b0);

    vbase = vcnt;
    send(8'hFF, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check_flags("ferr", 8'hC3, 1'b0, 1'b0, 1'b1);
    idle(200);
    chk("break_pulses", 16'(vcnt - vbase), 16'd0);
    check_flags("break", 8'hC3, 1'b0, 1'b0, 1'b1);
    ack();
    chk("ferr_ack", 16'(u_if.frame_err), 16'd0);

    vbase = vcnt;
    @(posedge clk); #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    idle(30);
    chk("glitch_pulses", 16'(vcnt - vbase), 16'd0);
    check_flags("glitch", 8'hC3, 1'b0, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    idle(4);
    chk("01_pulses", 16'(vcnt - vbase), 16'd1);
    check_flags("01", 8'h01, 1'b1, 1'b0, 1'b0);

    vbase = vcnt;
    send(8'h55, 1'b1, 1'b1);
    idle(4);
    chk("55_pulses", 16'(vcnt - vbase), 16'd1);
    check_flags("55_ackstop", 8'h55, 1'b1, 1'b0, 1'b0);

    vbase = vcnt;
    @(posedge clk); #1 rx = 1'b0;
    repeat (5 * CPB) @(posedge clk);
    #1 rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_valid", 16'(u_if.rx_valid), 16'd0);
    check_flags("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(200);
    chk("midrst_pulses", 16'(vcnt - vbase), 16'd0);
    check_flags("midrst_after", 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h81, 1'b1, 1'b0);
    idle(4);
    chk("81_pulses", 16'(vcnt - vbase), 16'd1);
    check_flags("81", 8'h81, 1'b1, 1'b0, 1'b0);

    chk("no_dbl_valid", 16'(dbl), 16'd0);
    chk("total_pulses", 16'(vcnt), 16'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
